qam_symbol_mapper: RTL and testbench



---
 rtl/qam_pkg.sv | 38 +++
 rtl/qam_level_lut.sv | 41 ++++
 rtl/qam_symbol_mapper.sv | 145 ++++++++++++++
 tb/tb_qam_symbol_mapper.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qam_pkg.sv
// Shared types and helpers for the streaming QAM symbol mapper.
package qam_pkg;

  // Constellation selected by mode_i; the last code is reserved and rejected.
  typedef enum logic [1:0] {
    MODE_BPSK  = 2'b00,
    MODE_QPSK  = 2'b01,
    MODE_16QAM = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_t;

  // IDLE: no word held. EMIT: a word is held and a symbol sits in the output registers.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Number of symbols a word of in_w bits produces in the given mode.
  function automatic int syms_per_word(mode_t m, int in_w);
    case (m)
      MODE_BPSK:  return in_w;
      MODE_QPSK:  return in_w / 2;
      MODE_16QAM: return in_w / 4;
      default:    return 1;
    endcase
  endfunction

  // Gray-coded two-bit amplitude level: 00 -3L, 01 -L, 11 +L, 10 +3L.
  function automatic int gray2_level(logic [1:0] b, int l);
    case (b)
      2'b00:   return -3 * l;
      2'b01:   return -l;
      2'b11:   return l;
      default: return 3 * l;
    endcase
  endfunction

endpackage

// File: rtl/qam_level_lut.sv
// Combinational map from (mode, symbol bits) to a signed I/Q constellation point.
module qam_level_lut
  import qam_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int AMP    = 8192,
  parameter int L16    = 2730
) (
  input  mode_t                     mode,
  input  logic [3:0]                bits,
  output logic signed [DATA_W-1:0]  level_i,
  output logic signed [DATA_W-1:0]  level_q
);

  localparam logic signed [DATA_W-1:0] POS_AMP = DATA_W'(AMP);
  localparam logic signed [DATA_W-1:0] NEG_AMP = DATA_W'(-AMP);

  // Select the constellation point; unused axes and the reserved mode give zero.
  always_comb begin
    level_i = '0;
    level_q = '0;
    case (mode)
      MODE_BPSK: begin
        level_i = bits[0] ? POS_AMP : NEG_AMP;
      end
      MODE_QPSK: begin
        level_i = bits[0] ? POS_AMP : NEG_AMP;
        level_q = bits[1] ? POS_AMP : NEG_AMP;
      end
      MODE_16QAM: begin
        level_i = DATA_W'(gray2_level(bits[1:0], L16));
        level_q = DATA_W'(gray2_level(bits[3:2], L16));
      end
      default: begin
        level_i = '0;
        level_q = '0;
      end
    endcase
  end

endmodule

// File: rtl/qam_symbol_mapper.sv
// Streaming constellation mapper: serialises IN_W-bit words into BPSK, QPSK or
// 16-QAM symbols LSB first, one registered I/Q pair per cycle, valid/ready on both sides.
module qam_symbol_mapper
  import qam_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int DATA_W = 16,
  parameter int AMP    = 8192,
  parameter int L16    = 2730
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                mode_i,
  input  logic [IN_W-1:0]           in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic signed [DATA_W-1:0]  out_i,
  output logic signed [DATA_W-1:0]  out_q,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      mode_err
);

  localparam int IDX_W = $clog2(IN_W + 1);

  state_t                     state_reg;
  state_t                     state_next;
  mode_t                      mode_reg;
  logic [IN_W-1:0]            shift_reg;
  logic [IDX_W-1:0]           idx_reg;

  logic                       fire_out;
  logic                       accept;
  logic                       advance;
  mode_t                      lut_mode;
  logic [3:0]                 lut_bits;
  logic signed [DATA_W-1:0]   lut_i;
  logic signed [DATA_W-1:0]   lut_q;
  logic                       first_last;
  logic                       next_last;
  logic [IN_W-1:0]            shift_from_in;
  logic [IN_W-1:0]            shift_from_reg;

  // Drop the bits of the symbol just consumed so the next symbol sits at bit 0.
  function automatic logic [IN_W-1:0] shift_word(logic [IN_W-1:0] word, mode_t m);
    case (m)
      MODE_BPSK:  return word >> 1;
      MODE_QPSK:  return word >> 2;
      MODE_16QAM: return word >> 4;
      default:    return word;
    endcase
  endfunction

  // Single constellation lookup feeding the output registers.
  qam_level_lut #(
    .DATA_W (DATA_W),
    .AMP    (AMP),
    .L16    (L16)
  ) u_lut (
    .mode    (lut_mode),
    .bits    (lut_bits),
    .level_i (lut_i),
    .level_q (lut_q)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: a new word always lands in EMIT, a consumed last symbol returns to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) state_next = ST_EMIT;
      end
      ST_EMIT: begin
        if (fire_out && out_last) state_next = accept ? ST_EMIT : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake decode and LUT source select; a new word bypasses the held one.
  always_comb begin
    fire_out       = out_valid & out_ready;
    in_ready       = ((state_reg == ST_IDLE) | (fire_out & out_last)) & (mode_i != MODE_RSVD);
    accept         = in_valid & in_ready;
    advance        = fire_out & ~out_last;
    lut_mode       = mode_reg;
    lut_bits       = shift_reg[3:0];
    if (accept) begin
      lut_mode = mode_t'(mode_i);
      lut_bits = in_data[3:0];
    end
    shift_from_in  = shift_word(in_data, mode_t'(mode_i));
    shift_from_reg = shift_word(shift_reg, mode_reg);
    first_last     = (syms_per_word(mode_t'(mode_i), IN_W) == 1);
    next_last      = ((int'(idx_reg) + 2) == syms_per_word(mode_reg, IN_W));
  end

  // Output and word registers: load on accept, step on advance, clear when the word drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_reg  <= MODE_BPSK;
      shift_reg <= '0;
      idx_reg   <= '0;
      out_i     <= '0;
      out_q     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      mode_err  <= 1'b0;
    end else begin
      if (in_valid && (mode_i == MODE_RSVD)) mode_err <= 1'b1;
      if (accept) begin
        mode_reg  <= mode_t'(mode_i);
        shift_reg <= shift_from_in;
        idx_reg   <= '0;
        out_i     <= lut_i;
        out_q     <= lut_q;
        out_valid <= 1'b1;
        out_last  <= first_last;
      end else if (advance) begin
        shift_reg <= shift_from_reg;
        idx_reg   <= idx_reg + 1'b1;
        out_i     <= lut_i;
        out_q     <= lut_q;
        out_last  <= next_last;
      end else if (fire_out) begin
        idx_reg   <= '0;
        out_i     <= '0;
        out_q     <= '0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qam_symbol_mapper.sv
// Directed bench for qam_symbol_mapper with a queue-based reference model.
module tb_qam_symbol_mapper;

  localparam int IN_W   = 8;
  localparam int DATA_W = 16;
  localparam int AMP    = 8192;
  localparam int L16    = 2730;

  logic                      clk;
  logic                      reset;
  logic [1:0]                mode_i;
  logic [IN_W-1:0]           in_data;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [DATA_W-1:0]  out_i;
  logic signed [DATA_W-1:0]  out_q;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_last;
  logic                      mode_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int i;
    int q;
    bit last;
  } sym_t;

  sym_t exp_q[$];
  bit   exp_err = 0;

  bit   prev_stall = 0;
  int   prev_i = 0;
  int   prev_q = 0;
  bit   prev_last = 0;

  qam_symbol_mapper #(
    .IN_W   (IN_W),
    .DATA_W (DATA_W),
    .AMP    (AMP),
    .L16    (L16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mode_i    (mode_i),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_i     (out_i),
    .out_q     (out_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .mode_err  (mode_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: symbol s of a word, computed from the constellation rules directly.
  function automatic void model_sym(input int mode, input int data, input int s,
                                    output int mi, output int mq, output bit ml);
    int bps;
    int n;
    int b;
    int gi;
    int gq;
    bps = (mode == 0) ? 1 : (mode == 1) ? 2 : 4;
    n   = IN_W / bps;
    b   = (data >> (s * bps)) & ((1 << bps) - 1);
    mi  = 0;
    mq  = 0;
    if (mode == 0) begin
      mi = (b != 0) ? AMP : -AMP;
    end else if (mode == 1) begin
      mi = ((b & 1) != 0) ? AMP : -AMP;
      mq = ((b & 2) != 0) ? AMP : -AMP;
    end else begin
      gi = b & 3;
      gq = (b >> 2) & 3;
      // Gray to binary index 0..3, then evenly spaced levels -3L,-L,+L,+3L.
      mi = (2 * ((((gi >> 1) & 1) * 2) + (((gi >> 1) ^ gi) & 1)) - 3) * L16;
      mq = (2 * ((((gq >> 1) & 1) * 2) + (((gq >> 1) ^ gq) & 1)) - 3) * L16;
    end
    ml = (s == n - 1);
  endfunction

  function automatic bit model_ready();
    bit busy_done;
    busy_done = (exp_q.size() == 0) || (out_ready && exp_q[0].last);
    return busy_done && (mode_i != 2'b11);
  endfunction

  // Model update on each edge: retire consumed symbol, then enqueue an accepted word.
  always @(posedge clk) begin
    if (!reset) begin
      bit rdy;
      rdy = model_ready();
      if (exp_q.size() != 0 && out_ready) begin
        $display("symbol i=%0d q=%0d last=%0d", exp_q[0].i, exp_q[0].q, exp_q[0].last);
        void'(exp_q.pop_front());
      end
      if (in_valid && rdy) begin
        int n;
        n = (mode_i == 2'd0) ? IN_W : (mode_i == 2'd1) ? IN_W / 2 : IN_W / 4;
        $display("accept mode=%0d data=0x%02h", mode_i, in_data);
        for (int s = 0; s < n; s++) begin
          sym_t e;
          model_sym(int'(mode_i), int'(in_data), s, e.i, e.q, e.last);
          exp_q.push_back(e);
        end
      end
      if (in_valid && mode_i == 2'b11) exp_err = 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      chk("out_valid", out_valid, exp_q.size() != 0);
      chk("in_ready", in_ready, model_ready());
      chk("mode_err", mode_err, exp_err);
      if (out_valid && exp_q.size() != 0) begin
        chk("out_i", out_i, exp_q[0].i);
        chk("out_q", out_q, exp_q[0].q);
        chk("out_last", out_last, exp_q[0].last);
      end
      if (prev_stall) begin
        chk("hold_i", out_i, prev_i);
        chk("hold_q", out_q, prev_q);
        chk("hold_last", out_last, prev_last);
      end
      prev_stall = out_valid && !out_ready;
      prev_i     = out_i;
      prev_q     = out_q;
      prev_last  = out_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Present a word from a falling edge and return at the rising edge that takes it.
  task automatic send_word(input logic [1:0] m, input logic [IN_W-1:0] d);
    bit taken;
    taken = 1'b0;
    @(negedge clk);
    mode_i   = m;
    in_data  = d;
    in_valid = 1'b1;
    for (int k = 0; k < 100 && !taken; k++) begin
      @(posedge clk);
      if (in_ready) taken = 1'b1;
    end
    chk("send_timeout", taken, 1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (exp_q.size() == 0) done = 1'b1;
    end
    chk("drain_timeout", done, 1);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    exp_q.delete();
    exp_err = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_i", out_i, 0);
    chk("rst_q", out_q, 0);
    chk("rst_last", out_last, 0);
    chk("rst_err", mode_err, 0);
  endtask

  initial begin
    int mi, mq;
    bit ml;
    int vcount;
    bit drop_valid;

    reset     = 1'b1;
    mode_i    = 2'b00;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Pin the reference model with hand-computed points.
    model_sym(1, 'hB4, 0, mi, mq, ml);
    chk("mdl_qpsk0_i", mi, -8192); chk("mdl_qpsk0_q", mq, -8192);
    model_sym(1, 'hB4, 1, mi, mq, ml);
    chk("mdl_qpsk1_i", mi, 8192);  chk("mdl_qpsk1_q", mq, -8192);
    model_sym(1, 'hB4, 3, mi, mq, ml);
    chk("mdl_qpsk3_i", mi, -8192); chk("mdl_qpsk3_q", mq, 8192); chk("mdl_qpsk3_l", ml, 1);
    model_sym(2, 'h2D, 0, mi, mq, ml);
    chk("mdl_qam0_i", mi, -2730);  chk("mdl_qam0_q", mq, 2730);
    model_sym(2, 'h2D, 1, mi, mq, ml);
    chk("mdl_qam1_i", mi, 8190);   chk("mdl_qam1_q", mq, -8190); chk("mdl_qam1_l", ml, 1);
    model_sym(0, 'h01, 1, mi, mq, ml);
    chk("mdl_bpsk1_i", mi, -8192); chk("mdl_bpsk1_l", ml, 0);

    // Reset state.
    #1;
    chk("init_valid", out_valid, 0);
    chk("init_i", out_i, 0);
    chk("init_err", mode_err, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // QPSK 0xB4: first symbol one cycle after accept.
    send_word(2'b01, 8'hB4);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("t1_valid", out_valid, 1);
    chk("t1_i0", out_i, -8192);
    chk("t1_q0", out_q, -8192);
    drain();

    // 16-QAM 0x2D, with mode_i changed mid-word to show it is ignored.
    send_word(2'b10, 8'h2D);
    @(negedge clk);
    in_valid = 1'b0;
    mode_i   = 2'b00;
    #1;
    chk("t2_i0", out_i, -2730);
    chk("t2_q0", out_q, 2730);
    @(negedge clk);
    #1;
    chk("t2_i1", out_i, 8190);
    chk("t2_q1", out_q, -8190);
    chk("t2_last", out_last, 1);
    drain();

    // BPSK 0x01.
    send_word(2'b00, 8'h01);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("t3_i0", out_i, 8192);
    chk("t3_q0", out_q, 0);
    drain();

    // Back-to-back QPSK 0x00, 0xFF: no bubble, in_ready only on last-symbol cycles.
    send_word(2'b01, 8'h00);
    vcount     = 0;
    drop_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) in_data = 8'hFF;
      if (drop_valid) in_valid = 1'b0;
      #1;
      if (out_valid) vcount++;
      chk("t4_ready", in_ready, (c % 4) == 3);
      if (in_ready && in_valid) drop_valid = 1'b1;
    end
    chk("t4_valid_cycles", vcount, 8);
    drain();

    // Backpressure on 16-QAM 0xC6 with out_ready toggling.
    out_ready = 1'b0;
    send_word(2'b10, 8'hC6);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("t5_i0", out_i, 8190);
    chk("t5_q0", out_q, -2730);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      out_ready = (c % 2) == 1;
    end
    out_ready = 1'b1;
    drain();

    // Reserved mode: rejected, sticky error.
    @(negedge clk);
    mode_i   = 2'b11;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    #1;
    chk("t6_ready", in_ready, 0);
    @(negedge clk);
    #1;
    chk("t6_err", mode_err, 1);
    chk("t6_valid", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    mode_i   = 2'b01;
    @(negedge clk);
    #1;
    chk("t6_sticky", mode_err, 1);

    // Reset mid-word, then the next word starts from symbol 0.
    send_word(2'b01, 8'hB4);
    @(negedge clk);
    in_valid = 1'b0;
    apply_reset();
    @(negedge clk);
    reset = 1'b0;
    send_word(2'b10, 8'h2D);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("t7_i0", out_i, -2730);
    chk("t7_q0", out_q, 2730);
    drain();

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
